// File: rtl/coeff_seq_loader_if.sv
// Handshake bundle between the coefficient-load sequencer and its host/datapath.
// load_coeff, clear_new_coefficient and load_done are one-cycle strobes; new_coefficient_set is a level.
interface coeff_seq_loader_if #(
  parameter int IDX_W = 2
);
  logic             new_coefficient_set;
  logic             modwait;
  logic             coeff_abort;
  logic             load_coeff;
  logic [IDX_W-1:0] coefficient_num;
  logic             clear_new_coefficient;
  logic             busy;
  logic             load_done;
  logic             timeout_err;

  // The host/datapath side drives the request and status levels.
  modport master (
    output new_coefficient_set, modwait, coeff_abort,
    input  load_coeff, coefficient_num, clear_new_coefficient, busy, load_done, timeout_err
  );

  modport slave (
    input  new_coefficient_set, modwait, coeff_abort,
    output load_coeff, coefficient_num, clear_new_coefficient, busy, load_done, timeout_err
  );
endinterface

// File: rtl/coeff_seq_loader.sv
// Coefficient-load sequencer: strobes NUM_COEFF slots into the FIR datapath, then acks the host.
// Optional WAIT timeout with sticky error state is enabled by defining COEFF_LOADER_TIMEOUT_EN.
module coeff_seq_loader #(
  parameter int NUM_COEFF   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                n_reset,
  coeff_seq_loader_if.slave   bus,
  output logic [2:0]          state_o
);

  localparam int IDX_W = $clog2(NUM_COEFF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  if (NUM_COEFF < 2 || NUM_COEFF > 256) begin : g_bad_num_coeff
    $error("coeff_seq_loader: NUM_COEFF must be in 2..256");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("coeff_seq_loader: TIMEOUT_CYC must be in 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3
`ifdef COEFF_LOADER_TIMEOUT_EN
    ,
    S_ERR   = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // High during the first WAIT cycle, when modwait has not yet reacted to the strobe.
  logic             guard_q, guard_d;

`ifdef COEFF_LOADER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC);
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_hit;

  assign timeout_hit = bus.modwait && ((cnt_q + 16'd1) == TO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LOAD) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    guard_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.new_coefficient_set) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        guard_d = 1'b1;
      end
      S_WAIT: begin
        if (!guard_q && !bus.modwait) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
`ifdef COEFF_LOADER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_ERR;
        end
`endif
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
`ifdef COEFF_LOADER_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort overrides every transition above, including the final WAIT->CLEAR.
    if (bus.coeff_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      guard_d = 1'b0;
    end
  end

  assign bus.load_coeff            = (state_q == S_LOAD);
  assign bus.coefficient_num       = idx_q;
  assign bus.clear_new_coefficient = (state_q == S_CLEAR);
  assign bus.load_done             = (state_q == S_CLEAR);
  assign bus.busy                  = (state_q != S_IDLE);
`ifdef COEFF_LOADER_TIMEOUT_EN
  assign bus.timeout_err           = (state_q == S_ERR);
`else
  assign bus.timeout_err           = 1'b0;
`endif
  assign state_o                   = state_q;

endmodule

// File: tb/tb_coeff_seq_loader.sv
// Directed bench for coeff_seq_loader: a 4-slot and an 8-slot instance share clock and reset.
// Edge index e counts posedges from the first edge that samples the stimulus; outputs are read 1ns after.
module tb_coeff_seq_loader;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  coeff_seq_loader_if #(.IDX_W(2)) if4 ();
  coeff_seq_loader_if #(.IDX_W(3)) if8 ();
  logic [2:0] st4, st8;

  coeff_seq_loader #(.NUM_COEFF(4), .TIMEOUT_CYC(10)) dut4 (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (if4),
    .state_o (st4)
  );

  coeff_seq_loader #(.NUM_COEFF(8), .TIMEOUT_CYC(255)) dut8 (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (if8),
    .state_o (st8)
  );

  int checks   = 0;
  int failures = 0;

`ifdef COEFF_LOADER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {load, clear, done, busy, timeout_err, num}
  function automatic logic [6:0] obs4();
    return {if4.load_coeff, if4.clear_new_coefficient, if4.load_done, if4.busy,
            if4.timeout_err, if4.coefficient_num};
  endfunction

  function automatic logic [7:0] obs8();
    return {if8.load_coeff, if8.clear_new_coefficient, if8.load_done, if8.busy,
            if8.timeout_err, if8.coefficient_num};
  endfunction

  task automatic test_reset();
    logic [6:0] exp4;
    n_reset = 1'b0;
    if4.new_coefficient_set = 1'b1; if4.modwait = 1'b0; if4.coeff_abort = 1'b0;
    if8.new_coefficient_set = 1'b1; if8.modwait = 1'b0; if8.coeff_abort = 1'b0;
    step();
    step();
    checks++;
    if (obs4() !== 7'd0 || st4 !== 3'd0) begin
      failures++;
      $display("FAIL reset4 got=%b st=%0d exp=0000000 st=0", obs4(), st4);
    end
    checks++;
    if (obs8() !== 8'd0 || st8 !== 3'd0) begin
      failures++;
      $display("FAIL reset8 got=%b st=%0d exp=00000000 st=0", obs8(), st8);
    end
    if8.new_coefficient_set = 1'b0;
    n_reset = 1'b1;
    checks++;
    if (if4.load_coeff !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_noload got=%b exp=0", if4.load_coeff);
    end
    // First edge with n_reset high samples the flag; the strobe follows it.
    for (int e = 0; e <= 3; e++) begin
      step();
      exp4 = {(e == 0 || e == 3), 1'b0, 1'b0, 1'b1, 1'b0, (e == 3) ? 2'd1 : 2'd0};
      checks++;
      if (obs4() !== exp4) begin
        failures++;
        $display("FAIL reset_first_load e=%0d got=%b exp=%b", e, obs4(), exp4);
      end
    end
    // Reset in the middle of the sequence drops all progress without a clear pulse.
    n_reset = 1'b0;
    if4.new_coefficient_set = 1'b0;
    step();
    n_reset = 1'b1;
    for (int e = 0; e <= 2; e++) begin
      checks++;
      if (obs4() !== 7'd0) begin
        failures++;
        $display("FAIL reset_mid_seq e=%0d got=%b exp=0000000", e, obs4());
      end
      step();
    end
  endtask

  task automatic test_nominal();
    logic [6:0] exp4;
    int         nm;
    if4.new_coefficient_set = 1'b1;
    if4.modwait = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      step();
      nm   = (e <= 12) ? ((e / 3 > 3) ? 3 : e / 3) : 0;
      exp4 = {(e % 3 == 0 && e <= 9), (e == 12), (e == 12), (e <= 12), 1'b0, 2'(nm)};
      checks++;
      if (obs4() !== exp4) begin
        failures++;
        $display("FAIL nominal e=%0d got=%b exp=%b", e, obs4(), exp4);
      end
      if (e == 12) if4.new_coefficient_set = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [6:0] exp4;
    logic       ld;
    int         nm;
    if4.new_coefficient_set = 1'b1;
    if4.modwait = 1'b0;
    // modwait is sampled high at edges 6..10, the first non-guard WAIT edges after slot 1.
    for (int e = 0; e <= 18; e++) begin
      step();
      ld   = (e == 0 || e == 3 || e == 11 || e == 14);
      nm   = (e < 3) ? 0 : (e < 11) ? 1 : (e < 14) ? 2 : (e <= 17) ? 3 : 0;
      exp4 = {ld, (e == 17), (e == 17), (e <= 17), 1'b0, 2'(nm)};
      checks++;
      if (obs4() !== exp4) begin
        failures++;
        $display("FAIL stall e=%0d got=%b exp=%b", e, obs4(), exp4);
      end
      if (e == 5)  if4.modwait = 1'b1;
      if (e == 10) if4.modwait = 1'b0;
      if (e == 17) if4.new_coefficient_set = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [6:0] exp4;
    logic       ld, bz;
    int         nm;
    if4.new_coefficient_set = 1'b1;
    if4.modwait = 1'b0;
    if4.coeff_abort = 1'b0;
    for (int e = 0; e <= 26; e++) begin
      step();
      ld = (e inside {0, 3, 6, 9, 11, 14, 17, 20, 24});
      bz = !(e inside {8, 10, 23, 25, 26});
      nm = (e >= 3 && e <= 5) || (e >= 14 && e <= 16) ? 1 :
           (e >= 6 && e <= 7) || (e >= 17 && e <= 19) ? 2 :
           (e >= 20 && e <= 22) ? 3 : 0;
      exp4 = {ld, 1'b0, 1'b0, bz, 1'b0, 2'(nm)};
      checks++;
      if (obs4() !== exp4) begin
        failures++;
        $display("FAIL abort e=%0d got=%b exp=%b", e, obs4(), exp4);
      end
      // Abort in WAIT guard, in LOAD, at WAIT->CLEAR, then in IDLE (ignored), then in LOAD again.
      if4.coeff_abort = (e inside {7, 9, 22, 23, 24});
      if (e == 24) if4.new_coefficient_set = 1'b0;
    end
  endtask

  task automatic test_depth();
    logic [7:0] exp8;
    int         nm, n_load, n_clear;
    n_load  = 0;
    n_clear = 0;
    if8.new_coefficient_set = 1'b1;
    if8.modwait = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      step();
      nm   = (e <= 24) ? ((e / 3 > 7) ? 7 : e / 3) : 0;
      exp8 = {(e % 3 == 0 && e <= 21), (e == 24), (e == 24), (e <= 24), 1'b0, 3'(nm)};
      checks++;
      if (obs8() !== exp8) begin
        failures++;
        $display("FAIL depth8 e=%0d got=%b exp=%b", e, obs8(), exp8);
      end
      if (if8.load_coeff === 1'b1) n_load++;
      if (if8.clear_new_coefficient === 1'b1) n_clear++;
      if (e == 24) if8.new_coefficient_set = 1'b0;
    end
    checks++;
    if (n_load != 8) begin
      failures++;
      $display("FAIL depth8_load_count got=%0d exp=8", n_load);
    end
    checks++;
    if (n_clear != 1) begin
      failures++;
      $display("FAIL depth8_clear_count got=%0d exp=1", n_clear);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp4;
    if4.new_coefficient_set = 1'b1;
    if4.modwait = 1'b1;
    if4.coeff_abort = 1'b0;
    // WAIT is entered at edge 1; the tenth WAIT cycle ends at edge 11.
    for (int e = 0; e <= 15; e++) begin
      step();
      exp4 = {(e == 0), 1'b0, 1'b0, 1'b1, (TO_EN && e >= 11), 2'd0};
      checks++;
      if (obs4() !== exp4) begin
        failures++;
        $display("FAIL timeout e=%0d got=%b exp=%b", e, obs4(), exp4);
      end
    end
    if4.coeff_abort = 1'b1;
    if4.new_coefficient_set = 1'b0;
    if4.modwait = 1'b0;
    step();
    if4.coeff_abort = 1'b0;
    checks++;
    if (obs4() !== 7'd0) begin
      failures++;
      $display("FAIL timeout_abort got=%b exp=0000000", obs4());
    end
    step();
    checks++;
    if (obs4() !== 7'd0) begin
      failures++;
      $display("FAIL timeout_idle got=%b exp=0000000", obs4());
    end
  endtask

  initial begin
    n_reset = 1'b0;
    if4.new_coefficient_set = 1'b0; if4.modwait = 1'b0; if4.coeff_abort = 1'b0;
    if8.new_coefficient_set = 1'b0; if8.modwait = 1'b0; if8.coeff_abort = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_depth();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
